// File: rtl/mul_div_unit_pkg.sv
// Shared types for the multiply/divide unit: operation encoding, word type and op decode helpers.
package mul_div_unit_pkg;

    localparam int unsigned WordWidth = 32;

    typedef logic [WordWidth-1:0] word_t;

    typedef enum logic [1:0] {
        MDU_MULT  = 2'd0,
        MDU_MULTU = 2'd1,
        MDU_DIV   = 2'd2,
        MDU_DIVU  = 2'd3
    } mdu_op_t;

    function automatic logic op_is_div(input mdu_op_t op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

    function automatic logic op_is_signed(input mdu_op_t op);
        return (op == MDU_MULT) || (op == MDU_DIV);
    endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// Request/response bundle between the EX stage and the multiply/divide unit.
interface mul_div_unit_if
    import mul_div_unit_pkg::*;
#(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    mdu_op_t          op;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             flush;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, src_a, src_b, flush,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, src_a, src_b, flush,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mdu_iter_core.sv
// One radix-2 step on the {acc,quot} pair: shift-add multiply or restoring shift-subtract divide.
module mdu_iter_core #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             i_is_div,
    input  logic [WIDTH-1:0] i_acc,
    input  logic [WIDTH-1:0] i_quot,
    input  logic [WIDTH-1:0] i_operand,
    output logic [WIDTH-1:0] o_acc,
    output logic [WIDTH-1:0] o_quot
);
    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_shift;
    logic [WIDTH:0] w_diff;

    always_comb begin
        w_sum   = {1'b0, i_acc} + {1'b0, i_operand};
        w_shift = {i_acc, i_quot[WIDTH-1]};
        w_diff  = w_shift - {1'b0, i_operand};
        o_acc   = i_acc;
        o_quot  = i_quot;
        if (i_is_div) begin
            // MSB of the difference is the borrow: set means the partial remainder is restored
            if (!w_diff[WIDTH]) begin
                o_acc  = w_diff[WIDTH-1:0];
                o_quot = {i_quot[WIDTH-2:0], 1'b1};
            end else begin
                o_acc  = w_shift[WIDTH-1:0];
                o_quot = {i_quot[WIDTH-2:0], 1'b0};
            end
        end else if (i_quot[0]) begin
            {o_acc, o_quot} = {w_sum, i_quot[WIDTH-1:1]};
        end else begin
            {o_acc, o_quot} = {1'b0, i_acc, i_quot[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit with FSM, sign handling and HI/LO output registers.
// Define MDU_FAST_MUL_EN to complete multiplies in a single cycle through a full multiplier.
module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    mul_div_unit_if.slave   io_mdu
);
    typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;
    localparam int unsigned CntW = $clog2(WIDTH);

    state_t           r_state, w_state_next;
    logic [CntW-1:0]  r_count;
    logic             r_is_div, r_neg_res, r_neg_rem;
    logic [WIDTH-1:0] r_acc, r_quot, r_opb, r_hi, r_lo;

    logic             w_launch, w_is_div, w_signed, w_fast;
    logic [WIDTH-1:0] w_abs_a, w_abs_b, w_step_acc, w_step_quot, w_fix_hi, w_fix_lo;
    logic [2*WIDTH-1:0] w_load, w_prod_fix;

    assign w_launch = (r_state == StIdle) && io_mdu.start && !io_mdu.flush;
    assign w_is_div = op_is_div(io_mdu.op);
    // Divide by zero runs unsigned so the raw dividend lands in acc and quot fills with ones
    assign w_signed = op_is_signed(io_mdu.op) && !(w_is_div && (io_mdu.src_b == '0));
    assign w_abs_a  = (w_signed && io_mdu.src_a[WIDTH-1]) ? -io_mdu.src_a : io_mdu.src_a;
    assign w_abs_b  = (w_signed && io_mdu.src_b[WIDTH-1]) ? -io_mdu.src_b : io_mdu.src_b;

`ifdef MDU_FAST_MUL_EN
    assign w_fast = !w_is_div;
    assign w_load = w_is_div ? {{WIDTH{1'b0}}, w_abs_a}
                             : ({{WIDTH{1'b0}}, w_abs_a} * {{WIDTH{1'b0}}, w_abs_b});
`else
    assign w_fast = 1'b0;
    assign w_load = {{WIDTH{1'b0}}, w_abs_a};
`endif

    mdu_iter_core #(.WIDTH(WIDTH)) u_iter_core (
        .i_is_div  (r_is_div),
        .i_acc     (r_acc),
        .i_quot    (r_quot),
        .i_operand (r_opb),
        .o_acc     (w_step_acc),
        .o_quot    (w_step_quot)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= StIdle;
        else          r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:  if (w_launch) w_state_next = w_fast ? StDone : StRun;
            StRun:   if (r_count == CntW'(WIDTH - 1)) w_state_next = StDone;
            StDone:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
        if (io_mdu.flush) w_state_next = StIdle;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count   <= '0;
            r_is_div  <= 1'b0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_acc     <= '0;
            r_quot    <= '0;
            r_opb     <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
        end else if (w_launch) begin
            r_count   <= '0;
            r_is_div  <= w_is_div;
            r_neg_res <= w_signed && (io_mdu.src_a[WIDTH-1] ^ io_mdu.src_b[WIDTH-1]);
            r_neg_rem <= w_signed && w_is_div && io_mdu.src_a[WIDTH-1];
            r_opb     <= w_abs_b;
            {r_acc, r_quot} <= w_load;
        end else if (r_state == StRun) begin
            r_count <= r_count + 1'b1;
            r_acc   <= w_step_acc;
            r_quot  <= w_step_quot;
        end else if ((r_state == StDone) && !io_mdu.flush) begin
            r_hi <= w_fix_hi;
            r_lo <= w_fix_lo;
        end
    end

    always_comb begin
        w_prod_fix = r_neg_res ? -{r_acc, r_quot} : {r_acc, r_quot};
        if (r_is_div) begin
            w_fix_hi = r_neg_rem ? -r_acc : r_acc;
            w_fix_lo = r_neg_res ? -r_quot : r_quot;
        end else begin
            w_fix_hi = w_prod_fix[2*WIDTH-1:WIDTH];
            w_fix_lo = w_prod_fix[WIDTH-1:0];
        end
    end

    // The fixed-up result is forwarded during DONE and held in r_hi/r_lo afterwards
    always_comb begin
        io_mdu.busy = (r_state != StIdle);
        io_mdu.done = (r_state == StDone) && !io_mdu.flush;
        io_mdu.hi   = io_mdu.done ? w_fix_hi : r_hi;
        io_mdu.lo   = io_mdu.done ? w_fix_lo : r_lo;
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: vector table plus flush, back-to-back start and async reset sequences.
module tb_mul_div_unit;
    import mul_div_unit_pkg::*;

`ifdef MDU_FAST_MUL_EN
    localparam int MulLat = 1;
`else
    localparam int MulLat = 33;
`endif
    localparam int DivLat = 33;

    typedef struct {
        string       name;
        mdu_op_t     op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    logic [31:0] last_hi = '0;
    logic [31:0] last_lo = '0;

    always #5 clk = ~clk;

    mul_div_unit_if #(.WIDTH(32)) mdu ();

    mul_div_unit #(.WIDTH(32)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .io_mdu  (mdu)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int lat;
        int exp_lat;
        logic [31:0] got_hi;
        logic [31:0] got_lo;
        exp_lat = op_is_div(v.op) ? DivLat : MulLat;
        got_hi  = '0;
        got_lo  = '0;
        lat     = 0;
        @(negedge clk);
        mdu.start = 1'b1;
        mdu.op    = v.op;
        mdu.src_a = v.a;
        mdu.src_b = v.b;
        for (int n = 1; n <= 40 && lat == 0; n++) begin
            @(negedge clk);
            if (n == 1) begin
                mdu.start = 1'b0;
                mdu.src_a = ~v.a;
                mdu.src_b = ~v.b;
                check({v.name, " busy"}, 64'(mdu.busy), 64'd1);
            end
            if (mdu.done) begin
                lat    = n;
                got_hi = mdu.hi;
                got_lo = mdu.lo;
            end
        end
        check({v.name, " latency"}, 64'(lat), 64'(exp_lat));
        check({v.name, " hi"}, 64'(got_hi), 64'(v.exp_hi));
        check({v.name, " lo"}, 64'(got_lo), 64'(v.exp_lo));
        @(negedge clk);
        check({v.name, " done pulse"}, 64'(mdu.done), 64'd0);
        last_hi = v.exp_hi;
        last_lo = v.exp_lo;
    endtask

    vec_t vecs[13];

    initial begin
        int saw_done;
        int next_free;
        int n_acc;
        int n_done;
        int due_q[$];
        logic [31:0] q_q[$];
        logic [31:0] r_q[$];
        logic [31:0] a_v;
        logic [31:0] b_v;

        vecs[0]  = '{"multu_max",   MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[1]  = '{"mult_neg3x7", MDU_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB};
        vecs[2]  = '{"div_neg7by2", MDU_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3]  = '{"divu_by0",    MDU_DIVU,  32'd100,      32'd0,        32'd100,      32'hFFFFFFFF};
        vecs[4]  = '{"div_ovf",     MDU_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[5]  = '{"divu_100by7", MDU_DIVU,  32'd100,      32'd7,        32'd2,        32'd14};
        vecs[6]  = '{"multu_shift", MDU_MULTU, 32'h12345678, 32'h10,       32'h00000001, 32'h23456780};
        vecs[7]  = '{"div_7byneg2", MDU_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD};
        vecs[8]  = '{"mult_5x6",    MDU_MULT,  32'd5,        32'd6,        32'd0,        32'd30};
        vecs[9]  = '{"div_neg5by0", MDU_DIV,   32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF};
        vecs[10] = '{"mult_minsq",  MDU_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[11] = '{"divu_maxby2", MDU_DIVU,  32'hFFFFFFFF, 32'd2,        32'd1,        32'h7FFFFFFF};
        vecs[12] = '{"divu_1000by3", MDU_DIVU, 32'd1000,     32'd3,        32'd1,        32'd333};

        mdu.start = 1'b0;
        mdu.op    = MDU_MULT;
        mdu.src_a = '0;
        mdu.src_b = '0;
        mdu.flush = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst busy", 64'(mdu.busy), 64'd0);
        check("rst done", 64'(mdu.done), 64'd0);
        check("rst hi", 64'(mdu.hi), 64'd0);
        check("rst lo", 64'(mdu.lo), 64'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) run_vec(vecs[i]);

        // Flush mid-divide
        saw_done = 0;
        @(negedge clk);
        mdu.start = 1'b1;
        mdu.op    = MDU_DIVU;
        mdu.src_a = 32'd1000;
        mdu.src_b = 32'd3;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (n == 1) mdu.start = 1'b0;
            if (n == 10) begin
                check("flush busy before", 64'(mdu.busy), 64'd1);
                mdu.flush = 1'b1;
            end
            if (n == 11) begin
                mdu.flush = 1'b0;
                check("flush busy after", 64'(mdu.busy), 64'd0);
            end
            if (mdu.done) saw_done = 1;
        end
        check("flush no done", 64'(saw_done), 64'd0);
        check("flush hi kept", 64'(mdu.hi), 64'(last_hi));
        check("flush lo kept", 64'(mdu.lo), 64'(last_lo));
        run_vec(vecs[12]);

        // Flush and start together
        saw_done = 0;
        @(negedge clk);
        mdu.start = 1'b1;
        mdu.flush = 1'b1;
        mdu.op    = MDU_MULTU;
        mdu.src_a = 32'd2;
        mdu.src_b = 32'd3;
        @(negedge clk);
        mdu.start = 1'b0;
        mdu.flush = 1'b0;
        check("flush+start busy", 64'(mdu.busy), 64'd0);
        for (int n = 0; n < 36; n++) begin
            @(negedge clk);
            if (mdu.done) saw_done = 1;
        end
        check("flush+start no done", 64'(saw_done), 64'd0);
        check("flush+start lo kept", 64'(mdu.lo), 64'(last_lo));

        // Start held every cycle with changing operands
        next_free = 0;
        n_acc     = 0;
        n_done    = 0;
        for (int i = 0; i < 112; i++) begin
            @(negedge clk);
            if (mdu.done) begin
                n_done++;
                if (due_q.size() > 0) begin
                    check("b2b done cycle", 64'(i), 64'(due_q[0]));
                    check("b2b quot", 64'(mdu.lo), 64'(q_q[0]));
                    check("b2b rem", 64'(mdu.hi), 64'(r_q[0]));
                    void'(due_q.pop_front());
                    void'(q_q.pop_front());
                    void'(r_q.pop_front());
                end else begin
                    check("b2b extra done", 64'd1, 64'(due_q.size()));
                end
            end
            if (i < 70) begin
                a_v       = 32'd1000 + 32'(i);
                b_v       = 32'(i) + 32'd3;
                mdu.start = 1'b1;
                mdu.op    = MDU_DIVU;
                mdu.src_a = a_v;
                mdu.src_b = b_v;
                if (i >= next_free) begin
                    due_q.push_back(i + DivLat);
                    q_q.push_back(a_v / b_v);
                    r_q.push_back(a_v % b_v);
                    next_free = i + DivLat + 1;
                    n_acc++;
                end
            end else begin
                mdu.start = 1'b0;
            end
        end
        check("b2b result count", 64'(n_done), 64'(n_acc));
        check("b2b pending", 64'(due_q.size()), 64'd0);

        // Asynchronous reset in the middle of a run
        @(negedge clk);
        mdu.start = 1'b1;
        mdu.op    = MDU_DIVU;
        mdu.src_a = 32'd81;
        mdu.src_b = 32'd9;
        @(negedge clk);
        mdu.start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async rst busy", 64'(mdu.busy), 64'd0);
        check("async rst done", 64'(mdu.done), 64'd0);
        check("async rst hi", 64'(mdu.hi), 64'd0);
        check("async rst lo", 64'(mdu.lo), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_vec(vecs[8]);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
